memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder.sv | 115 +++++++++++
 tb/tb_memory_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// memory_responder: single-port 32-bit word memory behind an edge-triggered
// Read/Write handshake with a programmable number of wait states.
module memory_responder #(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned ADDR_W      = 9
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] MAR_in,
    input  logic [31:0]       MDR_in,
    output logic [31:0]       Mdata_out,
    output logic              Mem_ready,
    output logic              Busy,
    output logic              Overrun
);

    localparam int unsigned DEPTH     = 1 << ADDR_W;
    localparam logic [2:0]  LAST_WAIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                rd_prev_q, wr_prev_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                is_wr_q, is_wr_d;
    logic                ovr_q, ovr_d;
    logic                busy_q, ready_q;
    logic [31:0]         mdata_q;
    logic [31:0]         mem_q [DEPTH];

    logic                rd_req, wr_req, req, access;

    assign rd_req = Read  & ~rd_prev_q;
    assign wr_req = Write & ~wr_prev_q;
    assign req    = rd_req | wr_req;
    assign access = (state_q == ACCESS);

    // Next-state logic: accept in IDLE, count wait states, access once, flag drops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        ovr_d   = ovr_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = MAR_in;
                    wdata_d = MDR_in;
                    is_wr_d = wr_req;   // write wins when both strobes rise together
                    cnt_d   = '0;
                    state_d = (WAIT_STATES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == LAST_WAIT) state_d = ACCESS;
                else                    cnt_d   = cnt_q + 3'd1;
            end
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The Mem_ready cycle is already IDLE, so a request there is accepted, not dropped.
        if (req && (state_q != IDLE)) ovr_d = 1'b1;
    end

    // Control and status registers with asynchronous active-low clear.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_prev_q <= 1'b0;
            wr_prev_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            is_wr_q   <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            mdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_prev_q <= Read;
            wr_prev_q <= Write;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_wr_q   <= is_wr_d;
            ovr_q     <= ovr_d;
            // Busy lags the state by one cycle so it ends with the Mem_ready cycle.
            busy_q    <= (state_q != IDLE);
            ready_q   <= access;
            if (access && !is_wr_q) mdata_q <= mem_q[addr_q];
        end
    end

    // Storage array; never cleared, so an aborted write leaves it untouched.
    always_ff @(posedge Clock) begin
        if (access && is_wr_q) mem_q[addr_q] <= wdata_q;
    end

    assign Mdata_out = mdata_q;
    assign Mem_ready = ready_q;
    assign Busy      = busy_q;
    assign Overrun   = ovr_q;

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed stimulus with a scoreboard of expected
// Mem_ready completions, checked by an independent monitor.
module tb_memory_responder;

    typedef struct {
        int          inst;
        int          cyc;
        logic [31:0] data;
        logic        ovr;
    } exp_t;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        rd2 = 1'b0, wr2 = 1'b0, rd0 = 1'b0, wr0 = 1'b0;
    logic [8:0]  mar2 = '0, mar0 = '0;
    logic [31:0] mdr2 = '0, mdr0 = '0;
    logic [31:0] dat2, dat0;
    logic        rdy2, busy2, ovr2, rdy0, busy0, ovr0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        sb[$];
    logic [31:0] last2 = '0, last0 = '0;
    logic        ovr_exp2 = 1'b0;
    int          nb;

    memory_responder #(.WAIT_STATES(2), .ADDR_W(9)) dut2 (
        .Clock(clk), .Clear(clear), .Read(rd2), .Write(wr2), .MAR_in(mar2), .MDR_in(mdr2),
        .Mdata_out(dat2), .Mem_ready(rdy2), .Busy(busy2), .Overrun(ovr2));

    memory_responder #(.WAIT_STATES(0), .ADDR_W(9)) dut0 (
        .Clock(clk), .Clear(clear), .Read(rd0), .Write(wr0), .MAR_in(mar0), .MDR_in(mdr0),
        .Mdata_out(dat0), .Mem_ready(rdy0), .Busy(busy0), .Overrun(ovr0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pop_check(input int inst, input logic [31:0] dat, input logic bsy, input logic ovr);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: inst %0d pulsed at cycle %0d, required no pulse", inst, cyc);
        end else begin
            e = sb.pop_front();
            chk("ready_inst", inst, e.inst);
            chk("ready_cycle", cyc, e.cyc);
            chk("mdata_at_ready", dat, e.data);
            chk("busy_at_ready", {31'd0, bsy}, 32'd1);
            chk("overrun_at_ready", {31'd0, ovr}, {31'd0, e.ovr});
        end
    endtask

    always @(negedge clk) begin
        if (rdy2) pop_check(2, dat2, busy2, ovr2);
        if (rdy0) pop_check(0, dat0, busy0, ovr0);
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("pending_completions", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic issue2(input logic w, input logic [8:0] a, input logic [31:0] d, input logic [31:0] rexp);
        @(negedge clk);
        mar2 = a;
        mdr2 = d;
        if (w) wr2 = 1'b1;
        else begin
            rd2   = 1'b1;
            last2 = rexp;
        end
        sb.push_back('{inst: 2, cyc: cyc + 4, data: last2, ovr: ovr_exp2});
        @(negedge clk);
        rd2 = 1'b0;
        wr2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1;
        chk("rst_mdata2", dat2, 0);
        chk("rst_ready2", {31'd0, rdy2}, 0);
        chk("rst_busy2", {31'd0, busy2}, 0);
        chk("rst_ovr2", {31'd0, ovr2}, 0);
        chk("rst_mdata0", dat0, 0);
        chk("rst_ready0", {31'd0, rdy0}, 0);
        chk("rst_busy0", {31'd0, busy0}, 0);
        chk("rst_ovr0", {31'd0, ovr0}, 0);
        repeat (3) @(negedge clk);
        clear = 1'b1;
        repeat (2) @(negedge clk);

        // Basic write, then read back.
        issue2(1'b1, 9'h05F, 32'h0000_00A5, 32'h0);
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy2) nb++;
        end
        chk("busy_cycles", nb, 3);
        drain();
        issue2(1'b0, 9'h05F, 32'h0, 32'h0000_00A5);
        drain();

        // Write held for six cycles while data and address keep changing.
        @(negedge clk);
        wr2 = 1'b1; mar2 = 9'h0A0; mdr2 = 32'h1111_0000;
        sb.push_back('{inst: 2, cyc: cyc + 4, data: last2, ovr: 1'b0});
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            mdr2 = 32'h1111_0000 + i;
            mar2 = 9'h0A0 + 9'(i);
        end
        @(negedge clk);
        wr2 = 1'b0;
        drain();
        issue2(1'b0, 9'h0A0, 32'h0, 32'h1111_0000);
        drain();

        // Read and Write rising together: write only, no overrun.
        @(negedge clk);
        rd2 = 1'b1; wr2 = 1'b1; mar2 = 9'h010; mdr2 = 32'h1234_5678;
        sb.push_back('{inst: 2, cyc: cyc + 4, data: last2, ovr: 1'b0});
        @(negedge clk);
        rd2 = 1'b0; wr2 = 1'b0;
        drain();
        chk("ovr_same_edge", {31'd0, ovr2}, 0);
        issue2(1'b0, 9'h010, 32'h0, 32'h1234_5678);
        drain();

        // Write raised while a read is in flight is dropped and sets Overrun.
        @(negedge clk);
        rd2 = 1'b1; mar2 = 9'h05F; last2 = 32'h0000_00A5;
        sb.push_back('{inst: 2, cyc: cyc + 4, data: 32'h0000_00A5, ovr: 1'b1});
        @(negedge clk);
        rd2 = 1'b0;
        @(negedge clk);
        chk("busy_at_overlap", {31'd0, busy2}, 1);
        wr2 = 1'b1; mdr2 = 32'hBAD0_BAD0;
        @(negedge clk);
        wr2 = 1'b0;
        drain();
        ovr_exp2 = 1'b1;
        chk("ovr_sticky", {31'd0, ovr2}, 1);
        issue2(1'b0, 9'h05F, 32'h0, 32'h0000_00A5);
        drain();

        // Reset during WAIT aborts a write; strobe high at release is accepted.
        issue2(1'b1, 9'h020, 32'hDEAD_BEEF, 32'h0);
        drain();
        @(negedge clk);
        wr2 = 1'b1; mar2 = 9'h020; mdr2 = 32'h0;
        @(negedge clk);
        wr2 = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("clr_mdata2", dat2, 0);
        chk("clr_ready2", {31'd0, rdy2}, 0);
        chk("clr_busy2", {31'd0, busy2}, 0);
        chk("clr_ovr2", {31'd0, ovr2}, 0);
        @(negedge clk);
        mar2 = 9'h020; rd2 = 1'b1;
        @(negedge clk);
        clear = 1'b1;
        ovr_exp2 = 1'b0;
        last2 = 32'hDEAD_BEEF;
        sb.push_back('{inst: 2, cyc: cyc + 4, data: 32'hDEAD_BEEF, ovr: 1'b0});
        @(negedge clk);
        rd2 = 1'b0;
        drain();

        // Zero wait states: back-to-back handoffs in each Mem_ready cycle.
        @(negedge clk);
        wr0 = 1'b1; mar0 = 9'h033; mdr0 = 32'hCAFE_F00D;
        sb.push_back('{inst: 0, cyc: cyc + 2, data: last0, ovr: 1'b0});
        @(negedge clk);
        @(negedge clk);
        chk("handoff_ready0", {31'd0, rdy0}, 1);
        wr0 = 1'b0; rd0 = 1'b1; mar0 = 9'h033; last0 = 32'hCAFE_F00D;
        sb.push_back('{inst: 0, cyc: cyc + 2, data: 32'hCAFE_F00D, ovr: 1'b0});
        @(negedge clk);
        @(negedge clk);
        rd0 = 1'b0; wr0 = 1'b1; mar0 = 9'h034; mdr0 = 32'h0BAD_F00D;
        sb.push_back('{inst: 0, cyc: cyc + 2, data: last0, ovr: 1'b0});
        @(negedge clk);
        @(negedge clk);
        wr0 = 1'b0; rd0 = 1'b1; mar0 = 9'h034; last0 = 32'h0BAD_F00D;
        sb.push_back('{inst: 0, cyc: cyc + 2, data: 32'h0BAD_F00D, ovr: 1'b0});
        @(negedge clk);
        @(negedge clk);
        rd0 = 1'b0;
        drain();
        chk("ovr0_final", {31'd0, ovr0}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
